// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: FSM states, command
// opcodes, accumulator modes, response codes and one-hot selector values.
package alu_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned ACC_W     = 2;
  localparam int unsigned IN_SEL_W  = 3;
  localparam int unsigned OUT_SEL_W = 7;
  localparam int unsigned ERR_W     = 2;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_CAPTURE = 2'b10,
    S_RESP    = 2'b11
  } state_e;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
  localparam logic [OP_W-1:0] OP_MULT = 3'd6;
  localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

  localparam logic [ACC_W-1:0] ACC_PERSIST = 2'd0;
  localparam logic [ACC_W-1:0] ACC_LOAD    = 2'd1;
  localparam logic [ACC_W-1:0] ACC_CLEAR   = 2'd2;
  localparam logic [ACC_W-1:0] ACC_ILL     = 2'd3;

  localparam logic [ERR_W-1:0] ERR_OK  = 2'd0;
  localparam logic [ERR_W-1:0] ERR_OVF = 2'd1;
  localparam logic [ERR_W-1:0] ERR_ILL = 2'd2;

  localparam logic [IN_SEL_W-1:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [IN_SEL_W-1:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [IN_SEL_W-1:0] IN_SEL_CLEAR   = 3'b001;

  localparam logic [OUT_SEL_W-1:0] OUT_SEL_AND  = 7'b1000000;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_OR   = 7'b0100000;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_NOT  = 7'b0010000;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_XOR  = 7'b0001000;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_ADD  = 7'b0000100;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_SUB  = 7'b0000010;
  localparam logic [OUT_SEL_W-1:0] OUT_SEL_MULT = 7'b0000001;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a command's op/acc fields into the ALU one-hot
// selectors, plus a flag for reserved encodings.
//   op, acc    : raw command fields
//   in_sel_c   : accumulator-mux one-hot
//   out_sel_c  : output-mux one-hot
//   illegal_c  : op or acc uses a reserved encoding
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]      op,
  input  logic [ACC_W-1:0]     acc,
  output logic [IN_SEL_W-1:0]  in_sel_c,
  output logic [OUT_SEL_W-1:0] out_sel_c,
  output logic                 illegal_c
);

  always_comb begin
    in_sel_c  = IN_SEL_PERSIST;
    out_sel_c = '0;
    illegal_c = 1'b0;

    case (acc)
      ACC_PERSIST: in_sel_c = IN_SEL_PERSIST;
      ACC_LOAD:    in_sel_c = IN_SEL_LOAD;
      ACC_CLEAR:   in_sel_c = IN_SEL_CLEAR;
      default:     illegal_c = 1'b1;
    endcase

    case (op)
      OP_AND:  out_sel_c = OUT_SEL_AND;
      OP_OR:   out_sel_c = OUT_SEL_OR;
      OP_NOT:  out_sel_c = OUT_SEL_NOT;
      OP_XOR:  out_sel_c = OUT_SEL_XOR;
      OP_ADD:  out_sel_c = OUT_SEL_ADD;
      OP_SUB:  out_sel_c = OUT_SEL_SUB;
      OP_MULT: out_sel_c = OUT_SEL_MULT;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command-side driver for the accumulator ALU. Accepts a command, drives the
// ALU selectors/operands with register timing, captures result/overflow and
// returns them over a response handshake.
//   cmd_*     : command handshake and fields
//   alu_*     : select/operand outputs to the ALU, result/overflow from it
//   rsp_*     : response handshake, data and error code
//   busy, cmd_count, err_count : status
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [ACC_W-1:0]     cmd_acc,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic [IN_SEL_W-1:0]  alu_in_sel,
  output logic [WIDTH-1:0]     alu_num1,
  output logic [WIDTH-1:0]     alu_num2,
  output logic [OUT_SEL_W-1:0] alu_out_sel,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [ERR_W-1:0]     rsp_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     cmd_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_e                 state_q, state_d;
  logic                   settle_q, settle_d;
  logic [OUT_SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic [IN_SEL_W-1:0]    in_sel_q, in_sel_d;
  logic [WIDTH-1:0]       num1_q, num1_d;
  logic [WIDTH-1:0]       num2_q, num2_d;
  logic [OUT_SEL_W-1:0]   out_sel_q, out_sel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [ERR_W-1:0]       rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]       cmd_count_q, cmd_count_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [IN_SEL_W-1:0]    dec_in_sel;
  logic [OUT_SEL_W-1:0]   dec_out_sel;
  logic                   dec_illegal;
  logic                   cmd_hs;

  alu_op_decode u_dec (
    .op        (cmd_op),
    .acc       (cmd_acc),
    .in_sel_c  (dec_in_sel),
    .out_sel_c (dec_out_sel),
    .illegal_c (dec_illegal)
  );

  assign cmd_hs = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    pend_sel_d  = pend_sel_q;
    in_sel_d    = IN_SEL_PERSIST;   // accumulator follows the result between commands
    num1_d      = num1_q;
    num2_d      = num2_q;
    out_sel_d   = out_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cmd_count_d = cmd_count_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          if (dec_illegal) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = ERR_ILL;
          end else begin
            state_d    = S_ISSUE;
            in_sel_d   = dec_in_sel;
            num1_d     = (cmd_acc == ACC_LOAD) ? cmd_a : '0;
            num2_d     = cmd_b;
            pend_sel_d = dec_out_sel;
          end
        end
      end
      S_ISSUE: begin
        // ALU input registers capture now; switch the output mux to the new op.
        state_d     = S_CAPTURE;
        out_sel_d   = pend_sel_q;
        settle_d    = 1'b1;
        cmd_count_d = cmd_count_q + CNT_W'(1);
      end
      S_CAPTURE: begin
        // One settle cycle lets the ALU output register reflect the new op.
        if (settle_q) begin
          settle_d = 1'b0;
        end else begin
          state_d    = S_RESP;
          rsp_data_d = alu_result;
          rsp_err_d  = alu_ovf ? ERR_OVF : ERR_OK;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if ((rsp_err_q != ERR_OK) && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 1'b0;
      pend_sel_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      in_sel_q    <= IN_SEL_CLEAR;
      num1_q      <= '0;
      num2_q      <= '0;
      out_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      cmd_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pend_sel_q  <= pend_sel_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      in_sel_q    <= in_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      out_sel_q   <= out_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_count_q <= cmd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign cmd_count   = cmd_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed scenarios plus randomized
// commands, checked against a transaction-level expectation model.
module tb_alu_cmd_driver;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_acc;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [2:0]       alu_in_sel;
  logic [WIDTH-1:0] alu_num1, alu_num2;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;
  logic [7:0]       err_count;

  alu_cmd_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .cmd_count(cmd_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Expectation model: what the ALU-facing outputs and counters should hold
  logic [6:0]       m_out_sel;
  logic [WIDTH-1:0] m_num1, m_num2;
  int               m_cmd_cnt;
  int               m_err_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out_sel = '0;
    m_num1    = '0;
    m_num2    = '0;
    m_cmd_cnt = 0;
    m_err_cnt = 0;
  endtask

  // One full command/response transaction. res/ovf is what the ALU shows
  // in the cycle the driver is expected to sample it; other cycles carry decoys.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] acc,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res, input logic ovf, input int hold);
    logic             ill;
    logic [WIDTH-1:0] e_data;
    logic [1:0]       e_err;
    logic [6:0]       e_sel;
    ill   = (op == 3'd7) || (acc == 2'd3);
    e_sel = 7'b1000000 >> op;

    @(negedge clk);
    check_eq("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_acc = acc; cmd_a = a; cmd_b = b;
    alu_result = WIDTH'($urandom); alu_ovf = 1'($urandom);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = WIDTH'($urandom); cmd_b = WIDTH'($urandom);
    cmd_op = 3'($urandom); cmd_acc = 2'($urandom);

    if (ill) begin
      e_data = '0;
      e_err  = 2'd2;
      check_eq("ill_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("ill_in_sel", 32'(alu_in_sel), 32'b100);
      check_eq("ill_out_sel", 32'(alu_out_sel), 32'(m_out_sel));
      check_eq("ill_num1", 32'(alu_num1), 32'(m_num1));
      check_eq("ill_num2", 32'(alu_num2), 32'(m_num2));
      check_eq("ill_cmd_count", 32'(cmd_count), 32'(m_cmd_cnt % 65536));
    end else begin
      m_num1 = (acc == 2'd1) ? a : '0;
      m_num2 = b;
      check_eq("iss_in_sel", 32'(alu_in_sel), 32'(3'b100 >> acc));
      check_eq("iss_num1", 32'(alu_num1), 32'(m_num1));
      check_eq("iss_num2", 32'(alu_num2), 32'(m_num2));
      check_eq("iss_out_sel_old", 32'(alu_out_sel), 32'(m_out_sel));
      check_eq("iss_busy", 32'(busy), 32'd1);
      check_eq("iss_ready", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'($urandom);      // ignored while no response is pending
      alu_result = WIDTH'($urandom); alu_ovf = 1'($urandom);
      @(posedge clk); #1;
      m_out_sel = e_sel;
      m_cmd_cnt++;
      check_eq("cap_out_sel", 32'(alu_out_sel), 32'(m_out_sel));
      check_eq("cap_in_sel", 32'(alu_in_sel), 32'b100);
      check_eq("cap_cmd_count", 32'(cmd_count), 32'(m_cmd_cnt % 65536));
      check_eq("cap_rsp_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'($urandom);
      alu_result = WIDTH'($urandom); alu_ovf = 1'($urandom);
      @(posedge clk); #1;
      check_eq("k2_rsp_valid", 32'(rsp_valid), 32'd0);
      rsp_ready  = 1'($urandom);
      alu_result = res; alu_ovf = ovf;
      @(posedge clk); #1;
      rsp_ready  = 1'b0;
      alu_result = ~res; alu_ovf = ~ovf;
      e_data = res;
      e_err  = ovf ? 2'd1 : 2'd0;
      check_eq("k3_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b0;
    check_eq("rsp_data", 32'(rsp_data), 32'(e_data));
    check_eq("rsp_err", 32'(rsp_err), 32'(e_err));

    for (int i = 0; i < hold; i++) begin
      alu_result = WIDTH'($urandom); alu_ovf = 1'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_data", 32'(rsp_data), 32'(e_data));
      check_eq("hold_err", 32'(rsp_err), 32'(e_err));
      check_eq("hold_ready", 32'(cmd_ready), 32'd0);
    end

    @(negedge clk);
    rsp_ready = 1'b1;
    // A command offered in the same cycle as the response handshake must be dropped.
    cmd_valid = 1'($urandom); cmd_op = 3'd4; cmd_acc = 2'd1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    if (e_err != 2'd0 && m_err_cnt < 255) m_err_cnt++;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_err_count", 32'(err_count), 32'(m_err_cnt));
    check_eq("post_cmd_count", 32'(cmd_count), 32'(m_cmd_cnt % 65536));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_in_sel"}, 32'(alu_in_sel), 32'b001);
    check_eq({tag, "_num1"}, 32'(alu_num1), 32'd0);
    check_eq({tag, "_num2"}, 32'(alu_num2), 32'd0);
    check_eq({tag, "_out_sel"}, 32'(alu_out_sel), 32'd0);
    check_eq({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_acc = '0; cmd_a = '0; cmd_b = '0;
    alu_result = '0; alu_ovf = 1'b0; rsp_ready = 1'b0;
    model_reset();

    // Reset with clear
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_values("rst");
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_in_sel", 32'(alu_in_sel), 32'b100);
    check_eq("rel_ready", 32'(cmd_ready), 32'd1);

    // Load/add, persist/sub, multiply overflow, illegal with backpressure
    do_cmd(3'd4, 2'd1, 8'h12, 8'h34, 8'h46, 1'b0, 0);
    do_cmd(3'd5, 2'd0, 8'h77, 8'h06, 8'h40, 1'b0, 1);
    do_cmd(3'd6, 2'd1, 8'h20, 8'h10, 8'h00, 1'b1, 2);
    check_eq("mult_err_count", 32'(err_count), 32'd1);
    do_cmd(3'd7, 2'd1, 8'h55, 8'haa, 8'h00, 1'b0, 5);
    do_cmd(3'd1, 2'd3, 8'h55, 8'haa, 8'h00, 1'b0, 0);
    do_cmd(3'd0, 2'd2, 8'hff, 8'h0f, 8'h00, 1'b0, 0);

    // Reset mid-command, asserted while capturing
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_acc = 2'd1; cmd_a = 8'h01; cmd_b = 8'h02;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    model_reset();
    check_reset_values("mid");
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("mid_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("mid_cmd_count", 32'(cmd_count), 32'd0);
    end
    do_cmd(3'd3, 2'd1, 8'h3c, 8'h0f, 8'h33, 1'b0, 0);

    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), WIDTH'($urandom),
             WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Drive err_count into saturation with illegal commands
    for (int n = 0; n < 260; n++) begin
      do_cmd(3'd7, 2'($urandom), WIDTH'($urandom), WIDTH'($urandom), '0, 1'b0, 0);
    end
    check_eq("err_sat", 32'(err_count), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
